// File: rtl/dcnn_s1_chain_psum_acc_pkg.sv
// Shared types and saturating add for the 1-D conv chain psum accumulator.
package dcnn_s1_pkg;

  localparam int DW = 16;

  typedef logic signed [DW-1:0] psum_t;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} acc_state_e;

  localparam psum_t PSUM_MAX = psum_t'({1'b0, {(DW-1){1'b1}}});
  localparam psum_t PSUM_MIN = psum_t'({1'b1, {(DW-1){1'b0}}});

  // One guard bit is enough: the sum of two DW-bit values fits in DW+1.
  function automatic psum_t sat_add(psum_t a, psum_t b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) return s[DW] ? PSUM_MIN : PSUM_MAX;
    return s[DW-1:0];
  endfunction

endpackage

// File: rtl/dcnn_s1_chain_psum_acc_if.sv
// Psum input stream and pixel output stream of the chain accumulator.
interface dcnn_s1_chain_psum_acc_if #(parameter int DW = 16);
  logic signed [DW-1:0] y_in;
  logic                 y_in_vld;
  logic signed [DW-1:0] out_data;
  logic                 out_vld;
  logic                 out_rdy;

  modport master (output y_in, y_in_vld, out_rdy, input out_data, out_vld);
  modport slave  (input y_in, y_in_vld, out_rdy, output out_data, out_vld);
endinterface

// File: rtl/dcnn_s1_chain_psum_acc_fifo.sv
// Small synchronous FIFO; head is read straight from the storage flops.
module dcnn_s1_psum_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic signed [DW-1:0] din,
  input  logic                 pop,
  output logic signed [DW-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic [CW-1:0]        count
);

  logic signed [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop_ok   = pop & ~empty;
    // A push into a full FIFO is still taken when a pop frees a slot this cycle.
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    dout     = empty ? '0 : mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dcnn_s1_chain_psum_acc.sv
// Accumulates chain psums across channel passes; final pass feeds an output FIFO.
// Optional macro DCNN_PSUM_RELU_EN clamps negative final-pass results to zero.
module dcnn_s1_chain_psum_acc
  import dcnn_s1_pkg::*;
#(
  parameter int DW         = dcnn_s1_pkg::DW,
  parameter int M_BITS     = 10,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [M_BITS-1:0] cfg_row_len,
  input  logic [M_BITS-1:0] cfg_ch_num,
  dcnn_s1_chain_psum_acc_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  acc_state_e        state_q, state_d;
  logic [M_BITS-1:0] col_cnt_q, col_cnt_d, ch_cnt_q, ch_cnt_d;
  logic [M_BITS-1:0] row_len_q, row_len_d, ch_num_q, ch_num_d;
  logic              ovf_q, ovf_d;

  psum_t row_q [DEPTH];
  psum_t entry, acc_res, fin_res;
  logic  take, last_pass, last_col, push, pop;
  logic  fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    row_len_d = row_len_q;
    ch_num_d  = ch_num_q;
    ovf_d     = ovf_q;

    entry     = row_q[col_cnt_q[AW-1:0]];
    last_pass = (ch_cnt_q == ch_num_q - M_BITS'(1));
    last_col  = (col_cnt_q == row_len_q - M_BITS'(1));
    take      = (state_q == ACC) & bus.y_in_vld;
    acc_res   = (ch_cnt_q == '0) ? bus.y_in : sat_add(entry, bus.y_in);
`ifdef DCNN_PSUM_RELU_EN
    fin_res   = acc_res[DW-1] ? '0 : acc_res;
`else
    fin_res   = acc_res;
`endif
    pop       = bus.out_vld & bus.out_rdy;
    push      = take & last_pass;
    if (push & fifo_full & ~pop) ovf_d = 1'b1;

    case (state_q)
      IDLE: if (start) begin
        state_d   = ACC;
        row_len_d = (cfg_row_len == '0) ? M_BITS'(1) : cfg_row_len;
        ch_num_d  = (cfg_ch_num == '0)  ? M_BITS'(1) : cfg_ch_num;
        col_cnt_d = '0;
        ch_cnt_d  = '0;
        ovf_d     = 1'b0;
      end
      ACC: if (take) begin
        if (last_col) begin
          col_cnt_d = '0;
          ch_cnt_d  = ch_cnt_q + M_BITS'(1);
          if (last_pass) state_d = DRAIN;
        end else begin
          col_cnt_d = col_cnt_q + M_BITS'(1);
        end
      end
      DRAIN: if (fifo_cnt == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy    = (state_q == ACC) | (state_q == DRAIN);
    done    = (state_q == DONE);
    ovf_err = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      ch_cnt_q  <= '0;
      row_len_q <= M_BITS'(1);
      ch_num_q  <= M_BITS'(1);
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      row_len_q <= row_len_d;
      ch_num_q  <= ch_num_d;
      ovf_q     <= ovf_d;
    end
  end

  // Row buffer is never reset: pass 0 overwrites every column it reads later.
  always_ff @(posedge clk) begin
    if (take) row_q[col_cnt_q[AW-1:0]] <= acc_res;
  end

  dcnn_s1_psum_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fin_res),
    .pop   (pop),
    .dout  (bus.out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.out_vld = ~fifo_empty;

endmodule

// File: tb/tb_dcnn_s1_chain_psum_acc.sv
// Directed bench with an expected-output queue checked on every pop.
module tb_dcnn_s1_chain_psum_acc;

  localparam int DW = 16;
  localparam int MB = 10;

  logic          clk, rst, start, busy, done, ovf_err;
  logic [MB-1:0] cfg_row_len, cfg_ch_num;
  int            n_assert = 0;
  int            n_fail   = 0;
  int            sb[$];

  dcnn_s1_chain_psum_acc_if #(.DW(DW)) bus ();

  dcnn_s1_chain_psum_acc #(.DW(DW), .M_BITS(MB), .DEPTH(256), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_row_len (cfg_row_len),
    .cfg_ch_num  (cfg_ch_num),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done),
    .ovf_err     (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int rl, input int cn);
    cfg_row_len = MB'(rl);
    cfg_ch_num  = MB'(cn);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic psum(input int v);
    bus.y_in     = DW'(v);
    bus.y_in_vld = 1'b1;
    tick();
    bus.y_in_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, int'(done), 1);
    tick();
    chk({tag, "_pulse_end"}, int'(done), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  // Pops happen at the next rising edge; compare at the falling edge before it.
  always @(negedge clk) begin
    if (!rst && bus.out_vld && bus.out_rdy) begin
      chk("sb_has_expect", int'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("out_data", int'(bus.out_data), sb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_row_len = '0; cfg_ch_num = '0;
    bus.y_in = '0; bus.y_in_vld = 1'b0; bus.out_rdy = 1'b0;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf_err), 0);
    chk("rst_vld", int'(bus.out_vld), 0);
    chk("rst_data", int'(bus.out_data), 0);
    rst = 1'b0;

    // Psum in IDLE is dropped.
    psum(77);
    tick();
    chk("idle_ignore_vld", int'(bus.out_vld), 0);

    // Single pass, 4 columns, one-cycle latency.
    bus.out_rdy = 1'b1;
    do_start(4, 1);
    chk("t1_busy", int'(busy), 1);
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(i);
      psum(i);
      chk("t1_lat_vld", int'(bus.out_vld), 1);
      chk("t1_lat_data", int'(bus.out_data), i);
    end
    psum(99);  // lands in DRAIN, must be ignored
    wait_done("t1_done");
    chk("t1_ovf", int'(ovf_err), 0);

    // Three channel passes over two columns; stray start mid-tile.
    do_start(2, 3);
    psum(10); psum(20);
    do_start(1, 1);
    psum(5); psum(-30);
    sb.push_back(16);
`ifdef DCNN_PSUM_RELU_EN
    sb.push_back(0);
`else
    sb.push_back(-9);
`endif
    psum(1); psum(1);
    wait_done("t2_done");

    // Saturation, row_len 0 taken as 1.
    do_start(0, 2);
    sb.push_back(32767);
    psum(30000); psum(10000);
    wait_done("t3_pos_done");
    do_start(0, 2);
`ifdef DCNN_PSUM_RELU_EN
    sb.push_back(0);
`else
    sb.push_back(-32768);
`endif
    psum(-30000); psum(-10000);
    wait_done("t3_neg_done");

    // Overflow: consumer stalled for a whole 6-column pass.
    bus.out_rdy = 1'b0;
    do_start(6, 1);
    for (int i = 1; i <= 6; i++) psum(i);
    chk("t4_ovf_set", int'(ovf_err), 1);
    chk("t4_head", int'(bus.out_data), 1);
    tick(); tick();
    chk("t4_hold_data", int'(bus.out_data), 1);
    chk("t4_hold_busy", int'(busy), 1);
    for (int i = 1; i <= 4; i++) sb.push_back(i);
    bus.out_rdy = 1'b1;
    wait_done("t4_done");
    chk("t4_ovf_sticky", int'(ovf_err), 1);

    // Reset mid-tile, then a fresh tile.
    bus.out_rdy = 1'b0;
    do_start(8, 1);
    chk("t5_ovf_clr", int'(ovf_err), 0);
    psum(11); psum(12); psum(13);
    rst = 1'b1;
    tick();
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_vld", int'(bus.out_vld), 0);
    rst = 1'b0;
    bus.out_rdy = 1'b1;
    do_start(2, 1);
    sb.push_back(7); sb.push_back(8);
    psum(7); psum(8);
    wait_done("t5_done");

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dcnn_s1_chain_psum_acc.md
Name: dcnn_s1_chain_psum_acc

Overview:
- Sits directly downstream of the last PE in the 1-D convolution chain.
- Consumes the finished per-column partial sums (psums) from the chain. Accumulates them across input-channel passes in a local row buffer, with saturation.
- On the final channel pass, emits completed output pixels through a small output FIFO with a valid/ready handshake.
- The chain cannot stall, so output overflow is flagged, never back-pressured.

Parameters:
- DW, 16, psum/data width (signed two's complement).
- M_BITS, 10, width of row-length and channel-count configuration.
- DEPTH, 256, row-buffer entries (maximum output row length).
- FIFO_DEPTH, 4, output FIFO entries (power of two).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset: synchronous, active-high.
- start  input  1  one-cycle pulse; latches config, begins a tile.
- cfg_row_len  input  M_BITS  psums per pass (1..DEPTH); 0 treated as 1.
- cfg_ch_num  input  M_BITS  number of channel passes; 0 treated as 1.
- y_in  input  DW  psum from the last PE.
- y_in_vld  input  1  y_in is a valid psum this cycle.
- out_data  output  DW  accumulated output pixel.
- out_vld  output  1  out_data valid.
- out_rdy  input  1  consumer accepts when out_vld & out_rdy.
- busy  output  1  high from start until done.
- done  output  1  one-cycle pulse when the tile is fully drained.
- ovf_err  output  1  sticky: a final-pass result was dropped because the FIFO was full.

Behaviour:
- Reset: state IDLE, col_cnt=0, ch_cnt=0, FIFO empty, out_vld=0, out_data=0, busy=0, done=0, ovf_err=0. Row-buffer contents are not reset; the first pass overwrites them. Reset mid-tile aborts the tile immediately.
- FSM states: IDLE, ACC, DRAIN, DONE.
- IDLE:
  - y_in_vld is ignored.
  - start -> ACC. Latches row_len and ch_num, clears ovf_err, col_cnt=0, ch_cnt=0.
- ACC, on each y_in_vld:
  - entry = buf[col_cnt].
  - ch_cnt==0: buf[col_cnt] <= y_in.
  - Otherwise: sum = entry + y_in in DW+1 bits, saturated to [-2^(DW-1), 2^(DW-1)-1], written back.
  - Read and write occur in the same cycle (register-array read, flop write), so back-to-back psums to any column are legal.
- Final pass (ch_cnt==ch_num-1):
  - The saturated result (or y_in itself when ch_num==1) is pushed to the FIFO. The buffer write is a don't-care.
  - If the FIFO is full and no pop happens the same cycle: the result is dropped and ovf_err is set.
  - A simultaneous pop and push when full is accepted.
- Counters, on each y_in_vld:
  - col_cnt++. When col_cnt==row_len-1, col_cnt wraps to 0 and ch_cnt++.
  - The wrap on the final pass -> DRAIN.
- DRAIN:
  - y_in_vld is ignored.
  - Waits for the FIFO to empty -> DONE.
- DONE: done=1 for one cycle, busy drops the same cycle -> IDLE.
- busy=1 in ACC, DRAIN and DONE-entry; busy=0 in IDLE and in the DONE cycle. start is ignored while busy.
- Latency: a final-pass psum sampled at edge t with the FIFO empty gives out_vld=1 after edge t (registered FIFO head). out_data is held stable while out_vld & !out_rdy.
- FIFO: FIFO_DEPTH entries with separate rd/wr pointers plus a count.

Optional Feature:
- Macro: DCNN_PSUM_RELU_EN.
- Defined: the final-pass result is clamped to 0 if negative, after saturation and before the FIFO push. Intermediate passes are unaffected.
- Undefined: signed results pass through unchanged.

Decomposition:
- Shared package dcnn_s1_pkg holds:
  - typedef psum_t (logic signed [DW-1:0]);
  - enum acc_state_e {IDLE, ACC, DRAIN, DONE};
  - localparams PSUM_MAX/PSUM_MIN;
  - function sat_add(psum_t a, psum_t b) returning psum_t.
- One sub-module: dcnn_s1_psum_fifo (synchronous FIFO, DW x FIFO_DEPTH, push/pop/full/empty/count).

Test Plan:
- ch_num=1, row_len=4, y_in=1,2,3,4, out_rdy=1 -> out_data 1,2,3,4, each one cycle after its input; done pulses after the last pop; ovf_err=0.
- ch_num=3, row_len=2:
  - Pass inputs {10,20}, {5,-30}, {1,1} -> outputs 16, -9.
  - With DCNN_PSUM_RELU_EN: outputs 16, 0.
- Saturation: ch_num=2, row_len=1, inputs 30000 then 10000 -> out 32767. Inputs -30000 then -10000 -> out -32768.
- Overflow: ch_num=1, row_len=6, out_rdy=0 throughout the pass -> 4 entries held, ovf_err=1. Then out_rdy=1 -> out_data 1,2,3,4, then done; ovf_err stays 1 until the next start.
- Reset mid-tile: rst asserted after 3 of 8 psums -> next cycle busy=0, out_vld=0. A new start with ch_num=1 yields only new-tile data.
- Ignored events:
  - start while busy does not restart the tile.
  - y_in_vld in IDLE or DRAIN produces no output and no counter change.
  - cfg_row_len=0 behaves as 1.
